// File: rtl/cpu_pkg.sv
// Shared types and sizing for the issue scoreboard.
package cpu_pkg;
  localparam int REG_W = 4;
  localparam int NREGS = 16;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_DRAIN,
    SB_HALTED
  } sb_state_t;
endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter: saturating up/down with clear.
// Simultaneous inc and dec leave the count unchanged.
module sb_counter
  import cpu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         at_max,
  output logic         overflow,
  output logic         underflow
);

  assign nonzero   = |count;
  assign at_max    = &count;
  assign overflow  = inc & ~dec & at_max;
  assign underflow = dec & ~inc & ~nonzero;

  // count update: clear wins, otherwise saturate at both ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc & ~dec & ~at_max)
      count <= count + W'(1);
    else if (dec & ~inc & nonzero)
      count <= count - W'(1);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard beside decode: counts in-flight writes per
// architectural register, accepts or stalls decode, and sequences drain.
//
//   state      | meaning
//   SB_RUN     | normal issue
//   SB_DRAIN   | issue blocked, waiting for outstanding writes to retire
//   SB_HALTED  | drain complete, absorbing until reset
module issue_scoreboard #(
  parameter int NREGS = cpu_pkg::NREGS,
  parameter int CNT_W = cpu_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iss_valid,
  input  logic [cpu_pkg::REG_W-1:0] iss_ra,
  input  logic [cpu_pkg::REG_W-1:0] iss_rb,
  input  logic                      iss_ra_use,
  input  logic                      iss_rb_use,
  input  logic [cpu_pkg::REG_W-1:0] iss_rt,
  input  logic                      iss_rt_write,
  output logic                      iss_accept,
  output logic                      stall,
  input  logic                      ret_valid,
  input  logic [cpu_pkg::REG_W-1:0] ret_rt,
  input  logic                      ret_write,
  input  logic                      flush,
  input  logic                      drain_req,
  output logic [NREGS-1:0]          busy_mask,
  output logic [3:0]                inflight,
  output logic                      halted,
  output logic                      err
);

  localparam int RW = cpu_pkg::REG_W;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] nz, mx, ovf, udf, rel, inc_vec;
  cpu_pkg::sb_state_t state, state_next;
  logic flush_q, run;
  logic haz_a, haz_b, haz_t, haz_cap;
  logic inc_en, ret_hit, dec_pre, dec_en;
  logic [CNT_W-1:0] net_a, net_b;

  // r0 is hardwired empty; every other register gets its own counter
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
      assign nz[r]  = 1'b0;
      assign mx[r]  = 1'b0;
      assign ovf[r] = 1'b0;
      assign udf[r] = 1'b0;
    end else begin : g_cnt
      sb_counter #(.W(CNT_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_vec[r]),
        .dec       (rel[r]),
        .clr       (flush),
        .count     (cnt[r]),
        .nonzero   (nz[r]),
        .at_max    (mx[r]),
        .overflow  (ovf[r]),
        .underflow (udf[r])
      );
    end
  end

  // per-register release strobe from the retiring instruction
  always_comb begin
    rel = '0;
    for (int r = 1; r < NREGS; r++)
      rel[r] = ret_valid & ret_write & (ret_rt == RW'(r));
  end

  // per-register increment strobe from the accepted instruction
  always_comb begin
    inc_vec = '0;
    for (int r = 1; r < NREGS; r++)
      inc_vec[r] = inc_en & (iss_rt == RW'(r));
  end

  // a same-cycle retire of the producer clears the source hazard
  assign net_a = cnt[iss_ra] - CNT_W'(rel[iss_ra]);
  assign net_b = cnt[iss_rb] - CNT_W'(rel[iss_rb]);
  assign haz_a = iss_ra_use & (iss_ra != '0) & (net_a != '0);
  assign haz_b = iss_rb_use & (iss_rb != '0) & (net_b != '0);
  assign haz_t = iss_rt_write & (iss_rt != '0) & mx[iss_rt] & ~rel[iss_rt];

  // inflight is 4 bits wide; hold a new write back once it is full so the
  // total can never wrap. dec_pre ignores the same-register case to keep
  // the accept path free of a combinational loop.
  assign ret_hit = ret_valid & ret_write & (ret_rt != '0) & ~flush;
  assign dec_pre = ret_hit & nz[ret_rt];
  assign haz_cap = iss_rt_write & (iss_rt != '0) & (&inflight) & ~dec_pre;

  assign iss_accept = iss_valid & ~flush & run & ~haz_a & ~haz_b & ~haz_t & ~haz_cap;
  assign stall      = iss_valid & ~iss_accept & ~flush;
  assign inc_en     = iss_accept & iss_rt_write & (iss_rt != '0);
  assign dec_en     = ret_hit & (nz[ret_rt] | (inc_en & (iss_rt == ret_rt)));
  assign busy_mask  = nz;

  // running total of tracked writes, cleared by flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      inflight <= '0;
    else if (flush)
      inflight <= '0;
    else
      inflight <= inflight + 4'(inc_en) - 4'(dec_en);
  end

  // sticky error on any counter over/underflow outside a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (~flush & ((|ovf) | (|udf)))
      err <= 1'b1;
  end

  // state register plus a one-cycle memory of flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= cpu_pkg::SB_RUN;
      flush_q <= 1'b0;
    end else begin
      state   <= state_next;
      flush_q <= flush;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      cpu_pkg::SB_RUN:
        if (drain_req) state_next = cpu_pkg::SB_DRAIN;
      cpu_pkg::SB_DRAIN:
        if (flush_q | ((inflight == '0) & ~ret_valid)) state_next = cpu_pkg::SB_HALTED;
      default:
        state_next = cpu_pkg::SB_HALTED;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    run    = (state == cpu_pkg::SB_RUN);
    halted = (state == cpu_pkg::SB_HALTED);
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_ra_use, iss_rb_use, iss_rt_write;
  logic [3:0]  iss_ra, iss_rb, iss_rt;
  logic        iss_accept, stall;
  logic        ret_valid, ret_write;
  logic [3:0]  ret_rt;
  logic        flush, drain_req;
  logic [15:0] busy_mask;
  logic [3:0]  inflight;
  logic        halted, err;

  int total = 0;
  int bad   = 0;

  issue_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_ra       (iss_ra),
    .iss_rb       (iss_rb),
    .iss_ra_use   (iss_ra_use),
    .iss_rb_use   (iss_rb_use),
    .iss_rt       (iss_rt),
    .iss_rt_write (iss_rt_write),
    .iss_accept   (iss_accept),
    .stall        (stall),
    .ret_valid    (ret_valid),
    .ret_rt       (ret_rt),
    .ret_write    (ret_write),
    .flush        (flush),
    .drain_req    (drain_req),
    .busy_mask    (busy_mask),
    .inflight     (inflight),
    .halted       (halted),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_ra = 0; iss_rb = 0; iss_ra_use = 0; iss_rb_use = 0;
    iss_rt = 0; iss_rt_write = 0;
    ret_valid = 0; ret_rt = 0; ret_write = 0;
    flush = 0; drain_req = 0;
  endtask

  task automatic issue(input logic [3:0] rt, input logic wr,
                       input logic [3:0] ra, input logic rau,
                       input logic [3:0] rb, input logic rbu);
    iss_valid = 1; iss_rt = rt; iss_rt_write = wr;
    iss_ra = ra; iss_ra_use = rau; iss_rb = rb; iss_rb_use = rbu;
  endtask

  task automatic retire(input logic [3:0] rt);
    ret_valid = 1; ret_rt = rt; ret_write = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    reset = 0;

    // r0 only: never a hazard, never tracked
    issue(0, 1, 0, 1, 0, 1); #1;
    chk("r0_accept", iss_accept, 1);
    chk("r0_stall", stall, 0);
    tick();
    chk("r0_busy", busy_mask, 0);
    chk("r0_inflight", inflight, 0);

    // writer r3, then dependent reader stalls until r3 retires
    issue(3, 1, 1, 1, 2, 1); #1;
    chk("w3_accept", iss_accept, 1);
    tick();
    chk("w3_busy", busy_mask, 16'h0008);
    chk("w3_inflight", inflight, 1);
    issue(4, 0, 3, 1, 0, 0); #1;
    chk("rd3_stall", stall, 1);
    chk("rd3_accept", iss_accept, 0);
    tick();
    chk("rd3_busy_hold", busy_mask, 16'h0008);
    retire(3); #1;
    chk("rd3_bypass_accept", iss_accept, 1);
    chk("rd3_bypass_stall", stall, 0);
    tick();
    chk("rd3_busy_clear", busy_mask, 0);
    chk("rd3_inflight", inflight, 0);
    idle();

    // three writes to r5 saturate its counter; fourth stalls until a retire
    issue(5, 1, 0, 0, 0, 0);
    repeat (3) tick();
    chk("w5x3_busy", busy_mask, 16'h0020);
    chk("w5x3_inflight", inflight, 3);
    #1;
    chk("w5_4th_stall", stall, 1);
    tick();
    chk("w5_4th_inflight", inflight, 3);
    retire(5); #1;
    chk("w5_4th_accept", iss_accept, 1);
    tick();
    chk("w5_swap_inflight", inflight, 3);
    chk("w5_swap_busy", busy_mask, 16'h0020);
    chk("w5_err", err, 0);
    idle();

    // fourth outstanding write, then flush with issue and retire present
    issue(6, 1, 0, 0, 0, 0); tick();
    chk("w6_inflight", inflight, 4);
    chk("w6_busy", busy_mask, 16'h0060);
    issue(9, 1, 0, 0, 0, 0); retire(5); flush = 1; #1;
    chk("flush_accept", iss_accept, 0);
    chk("flush_stall", stall, 0);
    tick();
    chk("flush_inflight", inflight, 0);
    chk("flush_busy", busy_mask, 0);
    chk("flush_err", err, 0);
    idle();

    // drain with two outstanding writes
    issue(1, 1, 0, 0, 0, 0); tick();
    issue(2, 1, 0, 0, 0, 0); tick();
    chk("drn_inflight", inflight, 2);
    idle(); drain_req = 1; tick();
    drain_req = 0;
    issue(8, 1, 0, 0, 0, 0); #1;
    chk("drn_block_stall", stall, 1);
    chk("drn_block_accept", iss_accept, 0);
    tick();
    chk("drn_block_inflight", inflight, 2);
    idle(); retire(1); tick();
    chk("drn_ret1_inflight", inflight, 1);
    chk("drn_ret1_halted", halted, 0);
    retire(2); tick();
    chk("drn_ret2_inflight", inflight, 0);
    chk("drn_ret2_halted", halted, 0);
    idle(); tick();
    chk("drn_halted", halted, 1);
    issue(8, 1, 0, 0, 0, 0); drain_req = 1; #1;
    chk("halt_stall", stall, 1);
    tick();
    chk("halt_absorb", halted, 1);
    idle();
    reset = 1; #1;
    chk("halt_reset", halted, 0);
    tick();
    reset = 0;

    // flush during drain: halt on the cycle after flush, even with ret_valid up
    issue(3, 1, 0, 0, 0, 0); tick();
    idle(); drain_req = 1; tick();
    drain_req = 0; flush = 1; tick();
    chk("fdrn_inflight", inflight, 0);
    chk("fdrn_halted_early", halted, 0);
    flush = 0; ret_valid = 1; ret_write = 1; ret_rt = 0; tick();
    chk("fdrn_halted", halted, 1);
    chk("fdrn_err", err, 0);
    idle();
    reset = 1; tick();
    reset = 0;

    // underflow on r7 sets a sticky err; reset mid-drain restores everything
    retire(7); tick();
    chk("uf_err", err, 1);
    idle(); tick();
    chk("uf_err_sticky", err, 1);
    issue(2, 1, 0, 0, 0, 0); tick();
    chk("rmd_busy", busy_mask, 16'h0004);
    idle(); drain_req = 1; tick();
    drain_req = 0;
    issue(4, 1, 0, 0, 0, 0); #1;
    chk("rmd_drain_stall", stall, 1);
    reset = 1; #1;
    chk("rmd_err", err, 0);
    chk("rmd_busy_clr", busy_mask, 0);
    chk("rmd_inflight", inflight, 0);
    chk("rmd_halted", halted, 0);
    chk("rmd_stall", stall, 0);
    tick();
    reset = 0; #1;
    chk("rmd_run_accept", iss_accept, 1);
    tick();
    chk("rmd_run_busy", busy_mask, 16'h0010);
    chk("rmd_run_inflight", inflight, 1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-hazard scheduler for the five-stage pipeline (fetch, decode, mem1, mem2, execute). Sits beside decode: it tracks in-flight register writes per architectural register, accepts or stalls the instruction in decode, releases entries when execute retires, clears on branch flush, and sequences an orderly drain to halt. It replaces per-stage ad-hoc stall comparisons with one counter-based scoreboard.

## Interface
Parameters:
- NREGS, 16, architectural register count; r0 is never tracked
- CNT_W, 2, per-register in-flight counter width; CNT_MAX = 2^CNT_W-1

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- iss_valid  in  1  decode holds a valid instruction
- iss_ra / iss_rb  in  4  source registers
- iss_ra_use / iss_rb_use  in  1  source is actually read
- iss_rt  in  4  destination register
- iss_rt_write  in  1  instruction writes iss_rt (sub, movl, movh, ld)
- iss_accept  out  1  instruction leaves decode this cycle
- stall  out  1  iss_valid & !iss_accept & !flush
- ret_valid  in  1  execute retires an instruction
- ret_rt  in  4  its destination
- ret_write  in  1  it wrote ret_rt
- flush  in  1  execute redirected pc; all younger work discarded
- drain_req  in  1  one-cycle request to stop issuing (halt seen)
- busy_mask  out  NREGS  bit i = counter i nonzero (bit 0 always 0)
- inflight  out  4  total outstanding tracked writes
- halted  out  1  drain complete
- err  out  1  sticky: counter overflow or underflow attempted

## Operation
- Source i hazard: use_i & reg_i != 0 & (cnt[reg_i] - rel[reg_i]) != 0, where rel[r] = ret_valid & ret_write & ret_rt == r (same-cycle retire bypasses; execute forwarding covers the value).
- Structural hazard: iss_rt_write & iss_rt != 0 & cnt[iss_rt] == CNT_MAX & !rel[iss_rt].
- iss_accept = iss_valid & !flush & state == RUN & no hazard.
- Counter update per register r != 0: +1 on accepted write to r, -1 on rel[r]; both together = unchanged.
- Retire of a register with count 0: count stays 0, err set. Increment at CNT_MAX is prevented by stall; err is set only if it is forced anyway.
- flush: all counters and inflight clear at the next edge; issue and retire in the flush cycle are ignored; err not set.
- inflight = sum of counters, maintained incrementally; never exceeds 15.
- FSM: RUN -> DRAIN on drain_req; DRAIN blocks issue (stall=iss_valid); DRAIN -> HALTED when inflight==0 & !ret_valid, or on the cycle after flush; HALTED absorbing until reset. drain_req in DRAIN/HALTED is ignored.

## Timing
- iss_accept, stall: combinational from registered state plus current inputs; no added latency, ready for the same-cycle decode enable.
- Counters, inflight, busy_mask, halted, err: registered, update at posedge clk.
- Reset (async assert, released synchronously by the system): counters 0, inflight 0, busy_mask 0, state RUN, halted 0, err 0; stall = 0 because it is combinational with iss_valid=0.
- Reset mid-drain returns to RUN with empty scoreboard.
- Issue-to-release: dependent instruction may issue in the same cycle its producer retires.

## Structure
- cpu_pkg: REG_W=4, NREGS, CNT_W, sb_state_t enum {SB_RUN, SB_DRAIN, SB_HALTED}.
- Sub-module sb_counter: saturating up/down counter with inc, dec, clr, and nonzero/max/underflow flags; instantiated for r1..r(NREGS-1).
- Top: hazard compare, inflight accumulator, FSM.

## Test plan
- Writer sub r3 accepted, then reader of r3 next cycle -> stall=1, busy_mask=0x0008; ret r3 arrives -> same-cycle accept, busy_mask returns 0.
- Three back-to-back writes to r5 (CNT_W=2) -> cnt=3, fourth writer stalls until one retire; err stays 0.
- Reads and writes of r0 only -> never stall, busy_mask stays 0, inflight 0.
- Four outstanding writes, flush with simultaneous iss_valid and ret_valid -> next cycle inflight=0, busy_mask=0, that issue not counted.
- drain_req with inflight=2 -> issue blocked, halted=1 one cycle after the second retire; with a flush during DRAIN, halted=1 on the cycle after the flush.
- Retire r7 with cnt 0 -> err=1 and sticky; assert reset mid-DRAIN -> all outputs return to reset values immediately.
